// File: rtl/apb_slave_regs.sv
// apb_slave_regs: APB3 completer with a bank of NUM_REGS 32-bit read/write
// registers and WAIT_CYCLES wait states per transfer.
// Build option: define APB_SLAVE_PSLVERR_EN to answer bad addresses
// (out-of-range index or misaligned PADDR[1:0]) with PSLVERR. Without it,
// PSLVERR stays 0, PADDR[1:0] is ignored, and out-of-range accesses are
// silently dropped (writes) or return 0 (reads).
//
// Handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0) seen
// in IDLE. PREADY is high for exactly one cycle, WAIT_CYCLES+1 cycles after
// setup. PRDATA/PSLVERR are valid only while PREADY=1. The write commits on
// the edge that ends the PREADY cycle, provided PSEL and PENABLE are still
// high. Dropping PSEL before then aborts the transfer with no side effects.
module apb_slave_regs #(
  parameter int ADDR_W      = 12,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [ADDR_W-1:0]        PADDR,
  input  logic [31:0]              PWDATA,
  output logic                     PREADY,
  output logic [31:0]              PRDATA,
  output logic                     PSLVERR,
  output logic [NUM_REGS*32-1:0]   regs_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0]  CNT_INIT   = 4'(WAIT_CYCLES);
  localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] regs [NUM_REGS];

  logic [ADDR_W-3:0] idx;
  logic [31:0]       idx_ext;
  logic              in_range;
  logic              addr_ok;
  logic              addr_err;
  logic [31:0]       rd_word;
  logic [31:0]       rd_resp;

  assign idx      = PADDR[ADDR_W-1:2];
  assign idx_ext  = 32'(idx);
  assign in_range = (idx_ext < NUM_REGS_U);

`ifdef APB_SLAVE_PSLVERR_EN
  assign addr_ok  = in_range && (PADDR[1:0] == 2'b00);
  assign addr_err = !addr_ok;
`else
  // The byte-lane bits carry no meaning in this build.
  logic unused_addr_bits;
  assign unused_addr_bits = ^PADDR[1:0];
  assign addr_ok  = in_range;
  assign addr_err = 1'b0;
`endif

  // Read mux: select the addressed register; an unmatched index yields 0.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_ext == 32'(i)) rd_word = regs[i];
    end
  end

  assign rd_resp = (!PWRITE && addr_ok) ? rd_word : 32'h0;

  // Transfer FSM: counts wait states and registers the completion response.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            if (WAIT_CYCLES == 0) begin
              state   <= DONE;
              PREADY  <= 1'b1;
              PRDATA  <= rd_resp;
              PSLVERR <= addr_err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (!PSEL) begin
            state   <= IDLE;
            cnt     <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
          end else if (cnt == 4'd1) begin
            state   <= DONE;
            cnt     <= '0;
            PREADY  <= 1'b1;
            PRDATA  <= rd_resp;
            PSLVERR <= addr_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // Completion lasts one cycle whether or not PSEL is still high.
          state   <= IDLE;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
        end
      endcase
    end
  end

  // Register bank: commit a valid write at the end of the completion cycle.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (state == DONE && PSEL && PENABLE && PWRITE && addr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (idx_ext == 32'(i)) regs[i] <= PWDATA;
      end
    end
  end

  // Flatten the bank for downstream consumers.
  always_comb begin
    regs_q = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_q[32*i +: 32] = regs[i];
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed testbench for apb_slave_regs. Three instances share the APB bus
// with private PSEL lines: u_w0 (WAIT_CYCLES=0), u_w1 (1) and u_w3 (3).
// Build with or without APB_SLAVE_PSLVERR_EN; the bad-address expectations
// follow the macro.
module tb_apb_slave_regs;

  logic        clk;
  logic        rst;
  logic        psel0, psel1, psel3;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;

  logic        pready0, pready1, pready3;
  logic [31:0] prdata0, prdata1, prdata3;
  logic        pslverr0, pslverr1, pslverr3;
  logic [255:0] rq0, rq1, rq3;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef APB_SLAVE_PSLVERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  apb_slave_regs #(.ADDR_W(12), .NUM_REGS(8), .WAIT_CYCLES(0)) u_w0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready0), .PRDATA(prdata0),
    .PSLVERR(pslverr0), .regs_q(rq0)
  );

  apb_slave_regs #(.ADDR_W(12), .NUM_REGS(8), .WAIT_CYCLES(1)) u_w1 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready1), .PRDATA(prdata1),
    .PSLVERR(pslverr1), .regs_q(rq1)
  );

  apb_slave_regs #(.ADDR_W(12), .NUM_REGS(8), .WAIT_CYCLES(3)) u_w3 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready3), .PRDATA(prdata3),
    .PSLVERR(pslverr3), .regs_q(rq3)
  );

  // Clock and global time limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic cur_pready(input int inst);
    case (inst)
      0: return pready0;
      1: return pready1;
      default: return pready3;
    endcase
  endfunction

  function automatic logic [31:0] cur_prdata(input int inst);
    case (inst)
      0: return prdata0;
      1: return prdata1;
      default: return prdata3;
    endcase
  endfunction

  function automatic logic cur_pslverr(input int inst);
    case (inst)
      0: return pslverr0;
      1: return pslverr1;
      default: return pslverr3;
    endcase
  endfunction

  task automatic drive_sel(input int inst, input logic v);
    psel0 = (inst == 0) ? v : 1'b0;
    psel1 = (inst == 1) ? v : 1'b0;
    psel3 = (inst == 3) ? v : 1'b0;
  endtask

  // One full transfer. Returns the number of access cycles up to and
  // including the PREADY cycle (-1 on timeout). Ends mid PREADY cycle with
  // PSEL/PENABLE still high so a following call is back-to-back.
  task automatic apb_xfer(input int inst, input logic wr, input logic [11:0] addr,
                          input logic [31:0] data, output int ncyc,
                          output logic [31:0] rdata, output logic err);
    int   n;
    logic got;
    @(posedge clk); #1;
    drive_sel(inst, 1'b1);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    @(posedge clk); #1;
    penable = 1'b1;
    n     = 1;
    got   = 1'b0;
    rdata = '0;
    err   = 1'b0;
    while (!got && n <= 20) begin
      @(negedge clk);
      if (cur_pready(inst) === 1'b1) begin
        got   = 1'b1;
        rdata = cur_prdata(inst);
        err   = cur_pslverr(inst);
      end else begin
        n++;
        @(posedge clk); #1;
      end
    end
    ncyc = got ? n : -1;
  endtask

  // Release the bus for one cycle; returns mid-cycle.
  task automatic go_idle();
    @(posedge clk); #1;
    drive_sel(0, 1'b0);
    penable = 1'b0;
    pwrite  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    psel0 = 1'b1; psel1 = 1'b1; psel3 = 1'b1;
    penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'hA5A5A5A5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (pready1 !== 1'b0) begin n_bad++; $display("FAIL reset_pready1: got %b want 0", pready1); end
    n_cmp++; if (prdata1 !== 32'h0) begin n_bad++; $display("FAIL reset_prdata1: got %h want 0", prdata1); end
    n_cmp++; if (pslverr1 !== 1'b0) begin n_bad++; $display("FAIL reset_pslverr1: got %b want 0", pslverr1); end
    n_cmp++; if (rq1 !== 256'h0) begin n_bad++; $display("FAIL reset_regs1: got %h want 0", rq1); end
    n_cmp++; if (pready0 !== 1'b0) begin n_bad++; $display("FAIL reset_pready0: got %b want 0", pready0); end
    n_cmp++; if (rq0 !== 256'h0) begin n_bad++; $display("FAIL reset_regs0: got %h want 0", rq0); end
    n_cmp++; if (pready3 !== 1'b0) begin n_bad++; $display("FAIL reset_pready3: got %b want 0", pready3); end
    n_cmp++; if (rq3 !== 256'h0) begin n_bad++; $display("FAIL reset_regs3: got %h want 0", rq3); end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_sel(0, 1'b0);
    pwrite = 1'b0;
  endtask

  task automatic test_write_wait1();
    int n; logic [31:0] rd; logic e;
    apb_xfer(1, 1'b1, 12'h004, 32'h0000EEEE, n, rd, e);
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL wr_w1_cycles: got %0d want 2", n); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL wr_w1_err: got %b want 0", e); end
    n_cmp++; if (rq1[63:32] !== 32'h0) begin n_bad++; $display("FAIL wr_w1_early: got %h want 0", rq1[63:32]); end
    go_idle();
    n_cmp++; if (rq1[63:32] !== 32'h0000EEEE) begin n_bad++; $display("FAIL wr_w1_commit: got %h want 0000eeee", rq1[63:32]); end
    n_cmp++; if (pready1 !== 1'b0) begin n_bad++; $display("FAIL wr_w1_ready_width: got %b want 0", pready1); end
  endtask

  task automatic test_readback_wait0();
    int n; logic [31:0] rd; logic e;
    apb_xfer(0, 1'b1, 12'h004, 32'h0000EEEE, n, rd, e);
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL wr_w0_cycles: got %0d want 1", n); end
    go_idle();
    apb_xfer(0, 1'b0, 12'h004, 32'h0, n, rd, e);
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL rd_w0_cycles: got %0d want 1", n); end
    n_cmp++; if (rd !== 32'h0000EEEE) begin n_bad++; $display("FAIL rd_w0_data: got %h want 0000eeee", rd); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL rd_w0_err: got %b want 0", e); end
    go_idle();
    n_cmp++; if (rq0 !== {192'h0, 32'h0000EEEE, 32'h0}) begin n_bad++; $display("FAIL rd_w0_no_side_effect: got %h", rq0); end
    apb_xfer(1, 1'b0, 12'h004, 32'h0, n, rd, e);
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL rd_w1_cycles: got %0d want 2", n); end
    n_cmp++; if (rd !== 32'h0000EEEE) begin n_bad++; $display("FAIL rd_w1_data: got %h want 0000eeee", rd); end
    go_idle();
  endtask

  task automatic test_back_to_back();
    int n1, n2, n3; logic [31:0] rd; logic e;
    apb_xfer(1, 1'b1, 12'h000, 32'h0000EEEE, n1, rd, e);
    apb_xfer(1, 1'b1, 12'h008, 32'h0000DDDD, n2, rd, e);
    apb_xfer(1, 1'b0, 12'h008, 32'h0, n3, rd, e);
    go_idle();
    n_cmp++; if (n1 !== 2) begin n_bad++; $display("FAIL b2b_first_cycles: got %0d want 2", n1); end
    n_cmp++; if (n2 !== 2) begin n_bad++; $display("FAIL b2b_second_cycles: got %0d want 2", n2); end
    n_cmp++; if (n3 !== 2) begin n_bad++; $display("FAIL b2b_read_cycles: got %0d want 2", n3); end
    n_cmp++; if (rd !== 32'h0000DDDD) begin n_bad++; $display("FAIL b2b_read_data: got %h want 0000dddd", rd); end
    n_cmp++; if (rq1[31:0] !== 32'h0000EEEE) begin n_bad++; $display("FAIL b2b_reg0: got %h want 0000eeee", rq1[31:0]); end
    n_cmp++; if (rq1[95:64] !== 32'h0000DDDD) begin n_bad++; $display("FAIL b2b_reg2: got %h want 0000dddd", rq1[95:64]); end
  endtask

  task automatic test_abort();
    int n; logic [31:0] rd; logic e; logic seen_ready;
    @(posedge clk); #1;
    drive_sel(3, 1'b1);
    penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'hFFFF0000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    n_cmp++; if (pready3 !== 1'b0) begin n_bad++; $display("FAIL abort_wait_ready: got %b want 0", pready3); end
    @(posedge clk); #1;
    drive_sel(3, 1'b0);
    penable = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (pready3 !== 1'b0) begin n_bad++; $display("FAIL abort_ready: got %b want 0", pready3); end
    n_cmp++; if (pslverr3 !== 1'b0) begin n_bad++; $display("FAIL abort_err: got %b want 0", pslverr3); end
    seen_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pready3 !== 1'b0) seen_ready = 1'b1;
    end
    n_cmp++; if (seen_ready !== 1'b0) begin n_bad++; $display("FAIL abort_late_ready: got %b want 0", seen_ready); end
    n_cmp++; if (rq3[127:96] !== 32'h0) begin n_bad++; $display("FAIL abort_reg3: got %h want 0", rq3[127:96]); end
    apb_xfer(3, 1'b0, 12'h00C, 32'h0, n, rd, e);
    go_idle();
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL abort_then_read_cycles: got %0d want 4", n); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL abort_then_read_data: got %h want 0", rd); end
  endtask

  task automatic test_bad_addr();
    int n; logic [31:0] rd; logic e;
    logic [255:0] exp_regs;
    logic [31:0]  exp_reg1;
    apb_xfer(1, 1'b1, 12'h020, 32'h00001111, n, rd, e);
    go_idle();
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL bad_wr_cycles: got %0d want 2", n); end
    n_cmp++; if (e !== ERR_EN) begin n_bad++; $display("FAIL bad_wr_err: got %b want %b", e, ERR_EN); end
    apb_xfer(1, 1'b0, 12'h020, 32'h0, n, rd, e);
    go_idle();
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL bad_rd_data: got %h want 0", rd); end
    n_cmp++; if (e !== ERR_EN) begin n_bad++; $display("FAIL bad_rd_err: got %b want %b", e, ERR_EN); end
    // Misaligned address: error in the checked build, lands on index 1 otherwise.
    apb_xfer(1, 1'b1, 12'h005, 32'h00002222, n, rd, e);
    go_idle();
    n_cmp++; if (e !== ERR_EN) begin n_bad++; $display("FAIL misalign_err: got %b want %b", e, ERR_EN); end
    // Highest valid register.
    apb_xfer(1, 1'b1, 12'h01C, 32'h00007777, n, rd, e);
    go_idle();
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL last_reg_err: got %b want 0", e); end
    exp_reg1 = ERR_EN ? 32'h0000EEEE : 32'h00002222;
    exp_regs = '0;
    exp_regs[31:0]    = 32'h0000EEEE;
    exp_regs[63:32]   = exp_reg1;
    exp_regs[95:64]   = 32'h0000DDDD;
    exp_regs[255:224] = 32'h00007777;
    n_cmp++; if (rq1 !== exp_regs) begin n_bad++; $display("FAIL bad_addr_bank: got %h want %h", rq1, exp_regs); end
  endtask

  task automatic test_reset_clears();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (rq1 !== 256'h0) begin n_bad++; $display("FAIL reset2_regs1: got %h want 0", rq1); end
    n_cmp++; if (rq0 !== 256'h0) begin n_bad++; $display("FAIL reset2_regs0: got %h want 0", rq0); end
    n_cmp++; if (pready1 !== 1'b0) begin n_bad++; $display("FAIL reset2_pready1: got %b want 0", pready1); end
  endtask

  initial begin
    rst = 1'b1;
    psel0 = 1'b0; psel1 = 1'b0; psel3 = 1'b0;
    penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    test_reset();
    test_write_wait1();
    test_readback_wait0();
    test_back_to_back();
    test_abort();
    test_bad_addr();
    test_reset_clears();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_slave_regs.md
# apb_slave_regs

APB3 completer containing a bank of 32-bit read/write registers with a programmable number of wait states. It is the responder for the team's `apb_master` and sits on the far side of the PSEL0 select line. It answers master read and write transfers, inserts wait states with PREADY, and optionally flags bad addresses with PSLVERR. All register contents are also exported as a flat bus for use by downstream logic.

## Interface
Parameters:
- ADDR_W, 12: PADDR width in bits; must be ≥ 2 + clog2(NUM_REGS).
- NUM_REGS, 8: number of 32-bit registers, 1..64.
- WAIT_CYCLES, 1: wait states per transfer, 0..15.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- PSEL  in  1  completer select.
- PENABLE  in  1  access-phase marker.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  byte address; register index is PADDR[ADDR_W-1:2].
- PWDATA  in  32  write data.
- PREADY  out  1  transfer completes in this cycle.
- PRDATA  out  32  read data, valid while PREADY=1 on a read.
- PSLVERR  out  1  error response, valid while PREADY=1.
- regs_q  out  NUM_REGS*32  register contents; register i occupies bits [32i+31:32i].

## Operation
- FSM has three states: IDLE, WAIT, DONE. PREADY, PRDATA and PSLVERR are registered.
- IDLE to DONE: on an edge with PSEL=1, PENABLE=0, when WAIT_CYCLES=0.
- IDLE to WAIT: on the same condition when WAIT_CYCLES>0; cnt is loaded with WAIT_CYCLES.
- WAIT: cnt decrements on each edge. When cnt=1, go to DONE.
- DONE: PREADY=1. Next edge returns to IDLE unconditionally.
- Latching on entry to DONE:
  - PRDATA = regs[index] for an in-range read, otherwise 0.
  - PSLVERR is set from the address check (see Configuration).
- Write commit: on the edge where state=DONE, PSEL=1, PENABLE=1, PWRITE=1 and the address is valid. regs[index] ← PWDATA.
- A write with PSLVERR=1 never modifies any register.
- Reads have no side effects.
- Abort: if PSEL=0 in WAIT or DONE, the FSM returns to IDLE on that edge. No write occurs, and PREADY/PSLVERR are 0 the next cycle.
- PADDR, PWRITE and PWDATA are sampled live. The master is required to hold them stable from setup through completion.
- PRESET=1 on an edge:
  - FSM → IDLE, cnt → 0.
  - PREADY=0, PRDATA=0, PSLVERR=0.
  - All registers → 0, so regs_q=0.
  - Reset takes priority over any in-flight transfer. A write pending in DONE is dropped.

## Timing
- Setup cycle (PSEL=1, PENABLE=0) is cycle S.
- PREADY rises in cycle S+1+WAIT_CYCLES and stays high for exactly 1 cycle.
- Access phase length = WAIT_CYCLES+1 cycles. PREADY=0 during cycles S+1..S+WAIT_CYCLES.
- Write data is visible on regs_q one cycle after the PREADY=1 cycle.
- A read returns data from the register value at the edge that ends cycle S+WAIT_CYCLES.
- A write and a read cannot overlap; only one transfer is in flight.
- Back-to-back transfers: a new setup in the cycle right after PREADY=1 is accepted normally.
- A setup presented while the FSM is not in IDLE is ignored. This is a protocol violation.

## Configuration
- APB_SLAVE_PSLVERR_EN defined:
  - PSLVERR=1 in the DONE cycle when index ≥ NUM_REGS or PADDR[1:0]≠0.
  - The write is suppressed and PRDATA=0.
- APB_SLAVE_PSLVERR_EN undefined:
  - PSLVERR is tied to 0.
  - PADDR[1:0] is ignored.
  - Out-of-range writes are silently dropped; out-of-range reads return 0.
  - PREADY timing is identical in both builds.

## Test plan
- Reset: hold PRESET=1 for 2 cycles with PSEL=1 → PREADY=0, PRDATA=0, PSLVERR=0, regs_q=0.
- Write, WAIT_CYCLES=1: PADDR=0x004, PWDATA=0x0000EEEE → PREADY=0 for 1 access cycle, then 1. regs_q[63:32]=0x0000EEEE the next cycle.
- Readback, WAIT_CYCLES=0: read PADDR=0x004 → PREADY=1 in the first access cycle, PRDATA=0x0000EEEE, PSLVERR=0.
- Back-to-back writes: 0x0000EEEE to 0x000, then 0x0000DDDD to 0x008 with no idle cycle → both committed; reading 0x008 returns 0x0000DDDD.
- Abort: drop PSEL during WAIT with WAIT_CYCLES=3, writing 0xFFFF0000 to 0x00C → FSM returns to IDLE, regs_q[127:96] unchanged at 0.
- Bad address, NUM_REGS=8: write 0x1111 to PADDR=0x020 →
  - with APB_SLAVE_PSLVERR_EN: PSLVERR=1 with PREADY, no register changes.
  - without it: PSLVERR=0, no register changes.
